control_fsm: RTL
================

# control_fsm

Multi-cycle control unit for the 16-bit accumulator processor. Decodes the instruction opcode and steps through fetch/decode/execute states. Each cycle it drives the datapath write enables and the 2-bit select lines of the `mux_16b_4input` instances that choose ALU operand B, next-PC source and accumulator write-back source. It sits directly upstream of those muxes: its select outputs connect straight to their `Op` ports.

## Interface
- `OPC_W`, default 4: opcode width, taken from instruction bits [15:12].
- `CLK` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Opcode` in OPC_W: IR[15:12], valid from DECODE onward.
- `Zero` in 1: high when accumulator == 0; sampled in BRANCH.
- `MemReady` in 1: memory handshake; present only with MEM_WAIT_EN.
- `PCWrite` out 1: PC register load.
- `IRWrite` out 1: instruction register load.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `AccWrite` out 1: accumulator load.
- `ALUSrcA` out 1: 0 = PC, 1 = accumulator.
- `ALUSrcB` out 2: 00 = MDR, 01 = constant 2, 10 = sign-extended imm, 11 = zero.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = and, 11 = or.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target, 11 = accumulator.
- `AccSrc` out 2: 00 = ALUOut, 01 = MDR, 10 = imm, 11 = PC.
- `Halted` out 1: high in HALT state.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LOAD, 6 STORE, 7 BEQZ, 8 BNEZ, 9 JUMP, A JAL, F HALT. B–E are illegal and execute as a NOP (DECODE → FETCH).
- States: INIT, FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT.
- Transitions:
  - INIT → FETCH.
  - FETCH → DECODE.
  - DECODE by opcode:
    - 0–4 → EXEC.
    - 5, 6 → MEM_ADDR.
    - 7, 8 → BRANCH.
    - 9, A → JUMP.
    - F → HALT.
    - illegal → FETCH.
  - EXEC → ALU_WB → FETCH.
  - MEM_ADDR → MEM_READ (LOAD) or MEM_WRITE (STORE).
  - MEM_READ → MEM_WB → FETCH.
  - MEM_WRITE → FETCH.
  - BRANCH → FETCH.
  - JUMP → FETCH.
  - HALT → HALT.
- Outputs are Moore-decoded from state. The one exception is PCWrite in BRANCH: it equals Zero for BEQZ and ~Zero for BNEZ.
- Per state, any output not listed is 0:
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - EXEC: ALUSrcA=1. ALUSrcB=00 for opcodes 0–3, 10 for ADDI. ALUOp = Opcode[1:0], forced to 00 for ADDI.
  - ALU_WB: AccWrite, AccSrc=00.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_READ: MemRead.
  - MEM_WB: AccWrite, AccSrc=01.
  - MEM_WRITE: MemWrite.
  - BRANCH: PCSource=01, PCWrite conditional as above.
  - JUMP: PCWrite, PCSource=10. For JAL also AccWrite with AccSrc=11; PC here is already PC+2.
  - HALT: Halted.
- Opcode is captured into an internal register on the DECODE cycle. Later states use the latched copy, so they are immune to Opcode changing after DECODE.

## Timing
- Reset asserted: state = INIT immediately (asynchronous) and all outputs are 0. Reset mid-instruction aborts it; no strobe is emitted afterwards.
- First rising edge after Reset deasserts: INIT → FETCH. The first fetch strobes appear in cycle 2.
- Latency in cycles, FETCH inclusive:
  - ALU/ADDI: 4.
  - LOAD: 5.
  - STORE: 4.
  - BEQZ/BNEZ, JUMP/JAL: 3.
  - illegal: 2.
- Zero is sampled combinationally in BRANCH. It must be stable before the rising edge that ends BRANCH.
- HALT is exited only by Reset.

## Configuration
- `CONTROL_MEM_WAIT_EN` defined:
  - The `MemReady` port exists.
  - FETCH, MEM_READ and MEM_WRITE hold their state and keep their outputs asserted until MemReady=1. PCWrite and IRWrite in FETCH are gated by MemReady.
  - Exit happens on the first edge with MemReady=1.
- Undefined: no MemReady port; every memory state lasts exactly one cycle.

## Structure
- Package `control_pkg` holds:
  - the state enum (4-bit encoding);
  - the opcode constants;
  - the select encodings for ALUSrcB, ALUOp, PCSource and AccSrc.
- No sub-module: one sequential state register block plus one combinational output/next-state block.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 while reset is held; FETCH in cycle 2 with MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
- Opcode=0 (ADD) → DECODE, EXEC (ALUSrcA=1, ALUSrcB=00, ALUOp=00), ALU_WB (AccWrite=1, AccSrc=00), back to FETCH after 4 cycles.
- Opcode=5 (LOAD) → MEM_ADDR (ALUSrcB=10), MEM_READ (MemRead=1), MEM_WB (AccSrc=01, AccWrite=1): 5 cycles. Opcode=6 (STORE) → MemWrite=1 in cycle 4.
- Opcode=7 with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. Repeat with Zero=0 → PCWrite=0. Opcode=8 gives the inverse.
- Opcode=A (JAL) → JUMP with PCWrite=1, PCSource=10, AccWrite=1, AccSrc=11. Opcode=F → Halted=1 held for 20 cycles until Reset. Opcode=C → FETCH directly after DECODE.
- With CONTROL_MEM_WAIT_EN: MemReady=0 for 3 cycles during MEM_READ → state held 4 cycles, MemRead held high, LOAD totals 8 cycles. Reset asserted mid-MEM_READ → INIT with outputs 0 immediately.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the accumulator processor control unit:
// state encoding, opcode map and datapath select encodings.
package control_pkg;

  typedef enum logic [3:0] {
    StInit,
    StFetch,
    StDecode,
    StExec,
    StAluWb,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StBranch,
    StJump,
    StHalt
  } state_e;

  // Opcodes, IR[15:12]; 4'hB..4'hE are illegal and run as a NOP
  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpAnd   = 4'h2;
  localparam logic [3:0] OpOr    = 4'h3;
  localparam logic [3:0] OpAddi  = 4'h4;
  localparam logic [3:0] OpLoad  = 4'h5;
  localparam logic [3:0] OpStore = 4'h6;
  localparam logic [3:0] OpBeqz  = 4'h7;
  localparam logic [3:0] OpBnez  = 4'h8;
  localparam logic [3:0] OpJump  = 4'h9;
  localparam logic [3:0] OpJal   = 4'hA;
  localparam logic [3:0] OpHalt  = 4'hF;

  // ALU operand B select
  localparam logic [1:0] SrcBMdr  = 2'b00;
  localparam logic [1:0] SrcBTwo  = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;
  localparam logic [1:0] SrcBZero = 2'b11;

  // ALU operation
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOr  = 2'b11;

  // Next-PC source
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcAcc    = 2'b11;

  // Accumulator write-back source
  localparam logic [1:0] AccSrcAluOut = 2'b00;
  localparam logic [1:0] AccSrcMdr    = 2'b01;
  localparam logic [1:0] AccSrcImm    = 2'b10;
  localparam logic [1:0] AccSrcPc     = 2'b11;

endpackage

// File: rtl/control_fsm.sv
// Multi-cycle control FSM for the 16-bit accumulator processor.
// Optional feature: define CONTROL_MEM_WAIT_EN to add the MemReady handshake,
// which stretches FETCH, MEM_READ and MEM_WRITE until memory is ready.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Zero,
`ifdef CONTROL_MEM_WAIT_EN
  input  logic             MemReady,
`endif
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             AccWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [1:0]       AccSrc,
  output logic             Halted
);

  state_e     state_q, state_d;
  logic [3:0] opc_q;
  logic [3:0] opc_in;
  logic       mem_ready;

  assign opc_in = 4'(Opcode);

`ifdef CONTROL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // State register and opcode latch; the latch keeps later states immune to IR changes
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StInit;
      opc_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opc_q <= opc_in;
      end
    end
  end

  // Next-state and Moore output decode (PCWrite in BRANCH also depends on Zero)
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AccWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SrcBMdr;
    ALUOp    = AluAdd;
    PCSource = PcSrcAlu;
    AccSrc   = AccSrcAluOut;
    Halted   = 1'b0;
    unique case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ALUSrcB = SrcBTwo;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut
        ALUSrcB = SrcBImm;
        case (opc_in)
          OpAdd, OpSub, OpAnd, OpOr, OpAddi: state_d = StExec;
          OpLoad, OpStore:                   state_d = StMemAddr;
          OpBeqz, OpBnez:                    state_d = StBranch;
          OpJump, OpJal:                     state_d = StJump;
          OpHalt:                            state_d = StHalt;
          default:                           state_d = StFetch;
        endcase
      end
      StExec: begin
        ALUSrcA = 1'b1;
        if (opc_q == OpAddi) begin
          ALUSrcB = SrcBImm;
          ALUOp   = AluAdd;
        end else begin
          ALUSrcB = SrcBMdr;
          ALUOp   = opc_q[1:0];
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        AccWrite = 1'b1;
        AccSrc   = AccSrcAluOut;
        state_d  = StFetch;
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (opc_q == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        MemRead = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        AccWrite = 1'b1;
        AccSrc   = AccSrcMdr;
        state_d  = StFetch;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StBranch: begin
        PCSource = PcSrcAluOut;
        PCWrite  = (opc_q == OpBeqz) ? Zero : ~Zero;
        state_d  = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcSrcJump;
        // PC already holds PC+2 here, which is the JAL link value
        if (opc_q == OpJal) begin
          AccWrite = 1'b1;
          AccSrc   = AccSrcPc;
        end
        state_d = StFetch;
      end
      StHalt: Halted = 1'b1;
      default: state_d = StInit;
    endcase
  end

endmodule
